// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds the FAULT state.
package fetch_pkg;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
    , ST_FAULT
`endif
  } state_e;

  // Next-PC source select for fetch_pc_reg.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIR
  } pc_sel_e;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response bus.
//   req  : request valid (fetch -> memory)
//   addr : request address (fetch -> memory)
//   ack  : one-cycle response strobe (memory -> fetch), only while req=1
//   data : instruction word, valid with ack (memory -> fetch)
interface fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with next-PC mux.
//   clock_i, rst_i : clock, async active-low reset (PC -> RESET_PC)
//   sel_i          : hold / +PC_STEP (wraps mod 2^32) / redirect
//   redir_pc_i     : redirect target
//   pc_o           : current PC
//   pc_next_o      : PC value after this edge
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        rst_i,
  input  pc_sel_e     sel_i,
  input  logic [31:0] redir_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:   pc_d = pc_q + PC_STEP;
      PC_REDIR: pc_d = redir_pc_i;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
//   clock_i, rst_i  : clock, async active-low reset
//   start_i         : level enable for fetching
//   stall_i         : downstream hold of the presented instruction
//   redirect_i      : taken branch/jump pulse, target in redirect_pc_i
//   imem            : instruction memory bus (fetch_if.master)
//   pc_o, inst_o    : presented instruction and its PC
//   valid_o         : pc_o/inst_o hold a live instruction
//   enable_o        : IF/ID load enable
//   flush_o         : IF/ID flush (copy of redirect_i)
//   misalign_o      : sticky misaligned-redirect fault (FETCH_MISALIGN_CHECK_EN only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_if.master       imem,
  output logic [31:0]   pc_o,
  output logic [31:0]   inst_o,
  output logic          valid_o,
  output logic          enable_o,
  output logic          flush_o
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic        misalign_o
`endif
);

  state_e      state_q, state_d;
  pc_sel_e     pc_sel;
  logic [31:0] pc_cur, pc_next, rpc;
  logic [31:0] addr_q, pc_out_q, inst_q;
  logic        cap;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misal;
  assign rpc   = redirect_pc_i;
  assign misal = redirect_i & (|redirect_pc_i[1:0]);
`else
  logic unused_rpc_lsb;
  assign rpc            = {redirect_pc_i[31:2], 2'b00};
  assign unused_rpc_lsb = ^redirect_pc_i[1:0];
`endif

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clock_i    (clock_i),
    .rst_i      (rst_i),
    .sel_i      (pc_sel),
    .redir_pc_i (rpc),
    .pc_o       (pc_cur),
    .pc_next_o  (pc_next)
  );

  // Redirect outranks ack, ack outranks stall. Acks are only looked at in
  // states that have a request outstanding.
  always_comb begin
    state_d = state_q;
    pc_sel  = PC_HOLD;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          pc_sel  = PC_REDIR;
          state_d = start_i ? ST_REQ : ST_IDLE;
        end else if (start_i) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          pc_sel  = PC_REDIR;
          // Acked data is stale; an unacked request must drain first.
          state_d = imem.ack ? ST_REQ : ST_DRAIN;
        end else if (imem.ack) begin
          cap     = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_sel  = PC_REDIR;
          state_d = start_i ? ST_REQ : ST_IDLE;
        end else if (!stall_i) begin
          pc_sel  = PC_INC;
          state_d = start_i ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect_i)    pc_sel  = PC_REDIR;
        else if (imem.ack) state_d = ST_REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misal) begin
      state_d = ST_FAULT;
      pc_sel  = PC_HOLD;
      cap     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      pc_out_q <= 32'h0;
      inst_q   <= INST_NOP;
    end else begin
      state_q <= state_d;
      // A new request always issues at the post-edge PC; DRAIN keeps the
      // old address because it never transitions into REQ on redirect.
      if (state_d == ST_REQ) addr_q <= pc_next;
      if (cap) begin
        pc_out_q <= pc_cur;
        inst_q   <= imem.data;
      end
    end
  end

  assign imem.req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem.addr = addr_q;
  assign pc_o      = pc_out_q;
  assign inst_o    = inst_q;
  // The held instruction is dead the moment a redirect arrives.
  assign valid_o   = (state_q == ST_HOLD) & ~redirect_i;
  assign enable_o  = valid_o & ~stall_i & ~redirect_i;
  assign flush_o   = redirect_i;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, inst_o;
  logic        valid_o, enable_o, flush_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_if bus();

  fetch_unit dut (
    .clock_i       (clk),
    .rst_i         (rst_n),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .enable_o      (enable_o),
    .flush_o       (flush_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        en, fl;          // combinational, before the edge
    logic        req;             // registered, after the edge
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic rd,
                       input logic [31:0] rp, input logic ak, input logic [31:0] dt);
    start_i       = st;
    stall_i       = sl;
    redirect_i    = rd;
    redirect_pc_i = rp;
    bus.ack       = ak;
    bus.data      = dt;
    #1;
  endtask

  // Clock edge, then drop the single-cycle pulses before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    bus.ack    = 1'b0;
    #1;
  endtask

  task automatic expect_st(input string nm, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] inst);
    chk({nm, ".req"},   {31'h0, bus.req}, {31'h0, req});
    chk({nm, ".addr"},  bus.addr,         addr);
    chk({nm, ".valid"}, {31'h0, valid_o}, {31'h0, vld});
    chk({nm, ".pc"},    pc_o,             pc);
    chk({nm, ".inst"},  inst_o,           inst);
  endtask

  initial begin
    // start stall redir rpc ack data | en fl | req addr vld pc inst
    tbl[0]  = '{1,0,0,0,0,0,            0,0, 1,32'h0,0,32'h0,32'h0};
    tbl[1]  = '{1,0,0,0,1,32'hA000_0000,0,0, 0,32'h0,1,32'h0,32'hA000_0000};
    tbl[2]  = '{1,0,0,0,0,0,            1,0, 1,32'h4,0,32'h0,32'hA000_0000};
    tbl[3]  = '{1,0,0,0,1,32'hA000_0004,0,0, 0,32'h4,1,32'h4,32'hA000_0004};
    tbl[4]  = '{1,0,0,0,0,0,            1,0, 1,32'h8,0,32'h4,32'hA000_0004};
    tbl[5]  = '{1,0,0,0,0,0,            0,0, 1,32'h8,0,32'h4,32'hA000_0004};
    tbl[6]  = '{1,0,0,0,0,0,            0,0, 1,32'h8,0,32'h4,32'hA000_0004};
    tbl[7]  = '{1,0,0,0,0,0,            0,0, 1,32'h8,0,32'h4,32'hA000_0004};
    tbl[8]  = '{1,0,0,0,1,32'hA000_0008,0,0, 0,32'h8,1,32'h8,32'hA000_0008};
    tbl[9]  = '{1,1,0,0,0,0,            0,0, 0,32'h8,1,32'h8,32'hA000_0008};
    tbl[10] = '{1,1,0,0,0,0,            0,0, 0,32'h8,1,32'h8,32'hA000_0008};
    tbl[11] = '{1,1,0,0,0,0,            0,0, 0,32'h8,1,32'h8,32'hA000_0008};
    tbl[12] = '{1,1,0,0,0,0,            0,0, 0,32'h8,1,32'h8,32'hA000_0008};
    tbl[13] = '{1,0,0,0,0,0,            1,0, 1,32'hC,0,32'h8,32'hA000_0008};
    tbl[14] = '{1,0,0,0,1,32'hA000_000C,0,0, 0,32'hC,1,32'hC,32'hA000_000C};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 0, 32'h0, 0, 32'h0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("reset.misalign", {31'h0, misalign_o}, 32'h0);
`endif
    rst_n = 1'b1;
    #1;
    tick();
    expect_st("idle_no_start", 0, 32'h0, 0, 32'h0, 32'h0);

    // Zero-wait stream, 3-cycle delayed ack, stall in HOLD.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].data);
      chk($sformatf("v%0d.enable", i), {31'h0, enable_o}, {31'h0, tbl[i].en});
      chk($sformatf("v%0d.flush", i),  {31'h0, flush_o},  {31'h0, tbl[i].fl});
      tick();
      expect_st($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].inst);
    end

    // Redirect while REQ at 0x10 is unacked: drain, drop, refetch 0x100.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    expect_st("req10", 1, 32'h10, 0, 32'hC, 32'hA000_000C);
    drive(1, 0, 1, 32'h100, 0, 0);
    chk("drain.flush",  {31'h0, flush_o},  32'h1);
    chk("drain.enable", {31'h0, enable_o}, 32'h0);
    tick();
    expect_st("drain", 1, 32'h10, 0, 32'hC, 32'hA000_000C);
    drive(1, 0, 0, 0, 1, 32'hDEAD_0010);
    tick();
    expect_st("drain_ack", 1, 32'h100, 0, 32'hC, 32'hA000_000C);
    drive(1, 0, 0, 0, 1, 32'h1111_0100);
    tick();
    expect_st("hold100", 0, 32'h100, 1, 32'h100, 32'h1111_0100);

    // Redirect coincident with ack: data dropped, next request 0x200.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    expect_st("req104", 1, 32'h104, 0, 32'h100, 32'h1111_0100);
    drive(1, 0, 1, 32'h200, 1, 32'hBAD0_0104);
    chk("redir_ack.flush", {31'h0, flush_o}, 32'h1);
    tick();
    expect_st("redir_ack", 1, 32'h200, 0, 32'h100, 32'h1111_0100);
    drive(1, 0, 0, 0, 1, 32'h2222_0200);
    tick();
    expect_st("hold200", 0, 32'h200, 1, 32'h200, 32'h2222_0200);

    // Redirect in HOLD: held instruction dies immediately.
    drive(1, 0, 1, 32'h300, 0, 0);
    chk("hold_redir.valid",  {31'h0, valid_o},  32'h0);
    chk("hold_redir.enable", {31'h0, enable_o}, 32'h0);
    tick();
    expect_st("hold_redir", 1, 32'h300, 0, 32'h200, 32'h2222_0200);

    // Second redirect in DRAIN overrides the target.
    drive(1, 0, 1, 32'h400, 0, 0);
    tick();
    expect_st("drain2a", 1, 32'h300, 0, 32'h200, 32'h2222_0200);
    drive(1, 0, 1, 32'h500, 0, 0);
    tick();
    expect_st("drain2b", 1, 32'h300, 0, 32'h200, 32'h2222_0200);
    drive(1, 0, 0, 0, 1, 32'hDEAD_0300);
    tick();
    expect_st("drain2_ack", 1, 32'h500, 0, 32'h200, 32'h2222_0200);
    drive(1, 0, 0, 0, 1, 32'h5555_0500);
    tick();
    expect_st("hold500", 0, 32'h500, 1, 32'h500, 32'h5555_0500);

    // start_i low in HOLD: consume, then back to IDLE.
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("stop.req",   {31'h0, bus.req}, 32'h0);
    chk("stop.valid", {31'h0, valid_o}, 32'h0);
    tick();
    chk("idle2.req", {31'h0, bus.req}, 32'h0);

    // Reset mid-REQ with a late ack.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    expect_st("req504", 1, 32'h504, 0, 32'h500, 32'h5555_0500);
    rst_n = 1'b0;
    #1;
    expect_st("rst_async", 0, 32'h0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 1, 32'hDEAD_0504);
    tick();
    expect_st("rst_ack", 0, 32'h0, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    expect_st("post_rst_idle", 0, 32'h0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    expect_st("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 1, 32'h7777_0000);
    tick();
    expect_st("post_rst_hold", 0, 32'h0, 1, 32'h0, 32'h7777_0000);

    // PC wraps modulo 2^32.
    drive(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tick();
    expect_st("wrap_req", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h7777_0000);
    drive(1, 0, 0, 0, 1, 32'h8888_FFFC);
    tick();
    expect_st("wrap_hold", 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h8888_FFFC);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    expect_st("wrap_next", 1, 32'h0, 0, 32'hFFFF_FFFC, 32'h8888_FFFC);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect: sticky fault, requests stop.
    drive(1, 0, 1, 32'h102, 0, 0);
    tick();
    chk("fault.misalign", {31'h0, misalign_o}, 32'h1);
    chk("fault.req",      {31'h0, bus.req},    32'h0);
    chk("fault.valid",    {31'h0, valid_o},    32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("fault_hold%0d.misalign", k), {31'h0, misalign_o}, 32'h1);
      chk($sformatf("fault_hold%0d.req", k),      {31'h0, bus.req},    32'h0);
    end
`else
    // Low address bits of a redirect target are ignored.
    drive(1, 0, 1, 32'h103, 1, 32'hDEAD_0000);
    tick();
    expect_st("lsb_force", 1, 32'h100, 0, 32'hFFFF_FFFC, 32'h8888_FFFC);
    drive(1, 0, 0, 0, 1, 32'h9999_0100);
    tick();
    expect_st("lsb_hold", 0, 32'h100, 1, 32'h100, 32'h9999_0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
